// File: rtl/pc_gen.sv
// Program-counter generator: holds the fetch PC, offers it over valid/ready and arbitrates redirects.
// Optional feature macro PC_MISALIGN_CHK_EN rejects redirect targets that are not STEP-aligned.
module pc_gen #(
    parameter int              ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RST_ADDR = '0,
    parameter int              NUM_REDIR = 2,
    parameter int              STEP      = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REDIR-1:0]        redir_valid_i,
    input  logic [NUM_REDIR*ADDR_W-1:0] redir_addr_i,
    input  logic                        hold_i,
    input  logic                        fetch_ready_i,
    input  logic                        halt_req_i,
    input  logic                        resume_i,
    output logic [ADDR_W-1:0]           pc_o,
    output logic                        fetch_valid_o,
    output logic [NUM_REDIR-1:0]        redir_taken_o,
    output logic                        halted_o,
    output logic                        misalign_o,
    output logic [ADDR_W-1:0]           misalign_addr_o
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [ADDR_W-1:0]   pc_next;
    logic                redir_any;
    logic [ADDR_W-1:0]   redir_target;
    logic                target_bad;
    logic                redir_apply;

    assign fetch_valid_o = (state == RUN) && !hold_i;

    // Lowest-index valid channel wins; BOOT ignores every redirect.
    always_comb begin
        redir_taken_o = '0;
        redir_any     = 1'b0;
        redir_target  = '0;
        if (state != BOOT) begin
            for (int k = 0; k < NUM_REDIR; k++) begin
                if (redir_valid_i[k] && !redir_any) begin
                    redir_any        = 1'b1;
                    redir_taken_o[k] = 1'b1;
                    redir_target     = redir_addr_i[k*ADDR_W +: ADDR_W];
                end
            end
        end
    end

`ifdef PC_MISALIGN_CHK_EN
    assign target_bad = (STEP == 4) ? (|redir_target[1:0]) : redir_target[0];
`else
    assign target_bad = 1'b0;
`endif

    assign redir_apply = redir_any && !target_bad;

    // A halt request in RUN blocks the sequential advance but not a redirect.
    always_comb begin
        pc_next    = pc_o;
        state_next = state;
        case (state)
            BOOT: begin
                state_next = RUN;
            end
            RUN: begin
                if (redir_apply) begin
                    pc_next = redir_target;
                end else if (fetch_valid_o && fetch_ready_i && !halt_req_i) begin
                    pc_next = pc_o + ADDR_W'(STEP);
                end
                if (halt_req_i) begin
                    state_next = HALT;
                end
            end
            HALT: begin
                if (redir_apply) begin
                    pc_next = redir_target;
                end
                if (resume_i && !halt_req_i) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= BOOT;
            pc_o     <= RST_ADDR;
            halted_o <= 1'b0;
        end else begin
            state    <= state_next;
            pc_o     <= pc_next;
            halted_o <= (state_next == HALT);
        end
    end

`ifdef PC_MISALIGN_CHK_EN
    // The rejected address is sticky until the next rejection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_o      <= 1'b0;
            misalign_addr_o <= '0;
        end else begin
            misalign_o <= redir_any && target_bad;
            if (redir_any && target_bad) begin
                misalign_addr_o <= redir_target;
            end
        end
    end
`else
    assign misalign_o      = 1'b0;
    assign misalign_addr_o = '0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: the driver queues hand-computed expectations, the monitor checks them each cycle.
module tb_pc_gen;

    localparam int          ADDR_W    = 32;
    localparam int          NUM_REDIR = 2;
    localparam int          STEP      = 4;
    localparam logic [31:0] RST_ADDR  = 32'h0000_0100;
`ifdef PC_MISALIGN_CHK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic [NUM_REDIR-1:0]        redir_valid_i = '0;
    logic [NUM_REDIR*ADDR_W-1:0] redir_addr_i = '0;
    logic                        hold_i = 1'b0;
    logic                        fetch_ready_i = 1'b0;
    logic                        halt_req_i = 1'b0;
    logic                        resume_i = 1'b0;
    logic [ADDR_W-1:0]           pc_o;
    logic                        fetch_valid_o;
    logic [NUM_REDIR-1:0]        redir_taken_o;
    logic                        halted_o;
    logic                        misalign_o;
    logic [ADDR_W-1:0]           misalign_addr_o;

    typedef struct packed {
        logic [31:0] pc;
        logic        fv;
        logic        hlt;
        logic [1:0]  tk;
        logic        mis;
        logic [31:0] maddr;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    pc_gen #(
        .ADDR_W(ADDR_W),
        .RST_ADDR(RST_ADDR),
        .NUM_REDIR(NUM_REDIR),
        .STEP(STEP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .redir_valid_i(redir_valid_i),
        .redir_addr_i(redir_addr_i),
        .hold_i(hold_i),
        .fetch_ready_i(fetch_ready_i),
        .halt_req_i(halt_req_i),
        .resume_i(resume_i),
        .pc_o(pc_o),
        .fetch_valid_o(fetch_valid_o),
        .redir_taken_o(redir_taken_o),
        .halted_o(halted_o),
        .misalign_o(misalign_o),
        .misalign_addr_o(misalign_addr_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
        end
    endtask

    // One cycle: drive inputs just after the rising edge and queue what the DUT must show this cycle.
    task automatic applyStimulus(input logic r, input logic [1:0] rv, input logic [31:0] a0,
                                 input logic [31:0] a1, input logic hold, input logic ready,
                                 input logic halt, input logic resume, input logic [31:0] epc,
                                 input logic efv, input logic ehlt, input logic [1:0] etk,
                                 input logic emis, input logic [31:0] emaddr);
        exp_t e;
        @(posedge clk);
        #1;
        rst           = r;
        redir_valid_i = rv;
        redir_addr_i  = {a1, a0};
        hold_i        = hold;
        fetch_ready_i = ready;
        halt_req_i    = halt;
        resume_i      = resume;
        e.pc    = epc;
        e.fv    = efv;
        e.hlt   = ehlt;
        e.tk    = etk;
        e.mis   = emis;
        e.maddr = emaddr;
        sb.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput("pc_o", pc_o, e.pc);
                checkOutput("fetch_valid_o", 32'(fetch_valid_o), 32'(e.fv));
                checkOutput("halted_o", 32'(halted_o), 32'(e.hlt));
                checkOutput("redir_taken_o", 32'(redir_taken_o), 32'(e.tk));
                checkOutput("misalign_o", 32'(misalign_o), 32'(e.mis));
                checkOutput("misalign_addr_o", misalign_addr_o, e.maddr);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        $display("[TB] pc_gen bench start, misalign check %0d", MIS_EN);
        // Boot: reset held, released, then the fetch sequence 0x100, 0x104, 0x108.
        applyStimulus(1, 2'b00, 32'h0, 32'h0, 0, 1, 0, 0, 32'h100, 0, 0, 2'b00, 0, 32'h0);
        applyStimulus(0, 2'b00, 32'h0, 32'h0, 0, 1, 0, 0, 32'h100, 0, 0, 2'b00, 0, 32'h0);
        applyStimulus(0, 2'b00, 32'h0, 32'h0, 0, 1, 0, 0, 32'h100, 1, 0, 2'b00, 0, 32'h0);
        applyStimulus(0, 2'b00, 32'h0, 32'h0, 0, 1, 0, 0, 32'h104, 1, 0, 2'b00, 0, 32'h0);
        // Stalls: advance only on handshake cycles, hold suppresses valid.
        applyStimulus(0, 2'b00, 32'h0, 32'h0, 0, 1, 0, 0, 32'h108, 1, 0, 2'b00, 0, 32'h0);
        applyStimulus(0, 2'b00, 32'h0, 32'h0, 0, 0, 0, 0, 32'h10C, 1, 0, 2'b00, 0, 32'h0);
        applyStimulus(0, 2'b00, 32'h0, 32'h0, 0, 1, 0, 0, 32'h10C, 1, 0, 2'b00, 0, 32'h0);
        applyStimulus(0, 2'b00, 32'h0, 32'h0, 0, 0, 0, 0, 32'h110, 1, 0, 2'b00, 0, 32'h0);
        applyStimulus(0, 2'b00, 32'h0, 32'h0, 1, 1, 0, 0, 32'h110, 0, 0, 2'b00, 0, 32'h0);
        applyStimulus(0, 2'b00, 32'h0, 32'h0, 0, 1, 0, 0, 32'h110, 1, 0, 2'b00, 0, 32'h0);
        // Wrap: jump to the top of the address space, then step past it.
        applyStimulus(0, 2'b10, 32'h0, 32'hFFFF_FFFC, 0, 1, 0, 0, 32'h114, 1, 0, 2'b10, 0, 32'h0);
        applyStimulus(0, 2'b00, 32'h0, 32'h0, 0, 1, 0, 0, 32'hFFFF_FFFC, 1, 0, 2'b00, 0, 32'h0);
        // Priority: both channels under hold, then channel 1 alone.
        applyStimulus(0, 2'b11, 32'h200, 32'h300, 1, 1, 0, 0, 32'h0, 0, 0, 2'b01, 0, 32'h0);
        applyStimulus(0, 2'b10, 32'h0, 32'h300, 0, 1, 0, 0, 32'h200, 1, 0, 2'b10, 0, 32'h0);
        applyStimulus(0, 2'b01, 32'h40, 32'h0, 0, 0, 0, 0, 32'h300, 1, 0, 2'b01, 0, 32'h0);
        // Halt at 0x40, redirect to 0x80 while halted, halt+resume stays, resume alone runs.
        applyStimulus(0, 2'b00, 32'h0, 32'h0, 0, 1, 1, 0, 32'h40, 1, 0, 2'b00, 0, 32'h0);
        applyStimulus(0, 2'b01, 32'h80, 32'h0, 0, 1, 0, 0, 32'h40, 0, 1, 2'b01, 0, 32'h0);
        applyStimulus(0, 2'b00, 32'h0, 32'h0, 0, 1, 1, 1, 32'h80, 0, 1, 2'b00, 0, 32'h0);
        applyStimulus(0, 2'b00, 32'h0, 32'h0, 0, 1, 0, 1, 32'h80, 0, 1, 2'b00, 0, 32'h0);
        applyStimulus(0, 2'b00, 32'h0, 32'h0, 0, 1, 0, 0, 32'h80, 1, 0, 2'b00, 0, 32'h0);
        applyStimulus(0, 2'b00, 32'h0, 32'h0, 0, 1, 0, 0, 32'h84, 1, 0, 2'b00, 0, 32'h0);
        // Mid-run reset takes effect at once; a redirect during BOOT is ignored.
        applyStimulus(1, 2'b00, 32'h0, 32'h0, 0, 1, 0, 0, 32'h100, 0, 0, 2'b00, 0, 32'h0);
        applyStimulus(0, 2'b01, 32'h500, 32'h0, 0, 1, 0, 0, 32'h100, 0, 0, 2'b00, 0, 32'h0);
        applyStimulus(0, 2'b00, 32'h0, 32'h0, 0, 1, 0, 0, 32'h100, 1, 0, 2'b00, 0, 32'h0);
        // Misaligned target 0x202 presented at pc 0x10 with ready high.
        applyStimulus(0, 2'b01, 32'h10, 32'h0, 0, 1, 0, 0, 32'h104, 1, 0, 2'b01, 0, 32'h0);
        applyStimulus(0, 2'b01, 32'h202, 32'h0, 0, 1, 0, 0, 32'h10, 1, 0, 2'b01, 0, 32'h0);
        applyStimulus(0, 2'b00, 32'h0, 32'h0, 0, 0, 0, 0, MIS_EN ? 32'h14 : 32'h202, 1, 0, 2'b00,
                      MIS_EN, MIS_EN ? 32'h202 : 32'h0);
        applyStimulus(0, 2'b00, 32'h0, 32'h0, 0, 0, 0, 0, MIS_EN ? 32'h14 : 32'h202, 1, 0, 2'b00,
                      0, MIS_EN ? 32'h202 : 32'h0);
        @(negedge clk);
        #1;
        checkOutput("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
